// File: rtl/board_io_ctrl.sv
// Board I/O peripheral: LED register, 7-seg scanner, debounced buttons with edge capture, switches.
// Latency: reads combinational; writes take effect at the next clk edge; seg/an/irq are registered (1 cycle).
// Backpressure: none; the bus is always ready and every access completes in one cycle.
//
// Ports: clk/rst (async active-low); ce/we/addr/data_i/data_o are the CPU data-bus slave port;
//        btn/sw are raw asynchronous board inputs; seg/an drive the display (active-low);
//        led drives the LEDs; irq flags an enabled button press.
// Optional: define BOARD_IO_RAW_SEG_EN to add raw segment mode (SEGCTRL[16]) and the SEGRAW register at word 7.
module board_io_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_BTN    = 5,
    parameter int NUM_SW     = 8,
    parameter int NUM_LED    = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    input  logic [NUM_BTN-1:0]    btn,
    input  logic [NUM_SW-1:0]     sw,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [NUM_LED-1:0]    led,
    output logic                  irq
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [NUM_LED-1:0]      led_q;
    logic [4*NUM_DIGITS-1:0] segdata_q;
    logic [NUM_DIGITS-1:0]   seg_en_q, seg_dp_q;
    logic [NUM_BTN-1:0]      irqen_q, evt_q, lvl_q;
    logic [NUM_BTN-1:0]      btn_s1, btn_s2;
    logic [NUM_SW-1:0]       sw_s1, sw_s2;
    logic [DEB_W-1:0]        deb_cnt [NUM_BTN];
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        dig_idx;
`ifdef BOARD_IO_RAW_SEG_EN
    logic                    raw_mode_q;
    logic [31:0]             segraw_q;
    logic [7:0]              raw_byte;
`endif

    logic [2:0]         word;
    logic               wr;
    logic [NUM_BTN-1:0] w1c, deb_done, rise;
    logic [3:0]         cur_nib;
    logic               cur_dp, cur_en;
    logic [7:0]         seg_nxt;
    logic [31:0]        rd;
    logic               unused_bits;

    assign word        = addr[4:2];
    assign wr          = ce & we;
    assign w1c         = (wr && word == 3'd5) ? data_i[NUM_BTN-1:0] : '0;
    assign unused_bits = ^{addr[1:0], data_i};
    assign led         = led_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // A button's level is accepted on the edge where its disagreeing sample has
    // already been seen DEB_CYCLES-1 times in a row, i.e. on the DEB_CYCLES-th one.
    always_comb begin
        deb_done = '0;
        for (int i = 0; i < NUM_BTN; i++)
            deb_done[i] = (btn_s2[i] != lvl_q[i]) && (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1));
    end
    assign rise = deb_done & btn_s2;

    // Current-digit selection by loop avoids variable part-selects past the vector ends.
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dig_idx == IDX_W'(d)) begin
                cur_nib = segdata_q[4*d +: 4];
                cur_dp  = seg_dp_q[d];
                cur_en  = seg_en_q[d];
            end
        end
    end

`ifdef BOARD_IO_RAW_SEG_EN
    // Only the first four digits have a raw byte; higher digits stay dark in raw mode.
    always_comb begin
        raw_byte = 8'h00;
        for (int d = 0; d < 4 && d < NUM_DIGITS; d++)
            if (dig_idx == IDX_W'(d)) raw_byte = segraw_q[8*d +: 8];
    end
    assign seg_nxt = raw_mode_q ? ~raw_byte : {~cur_dp, hex7(cur_nib)};
`else
    assign seg_nxt = {~cur_dp, hex7(cur_nib)};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= '0;
            segdata_q <= '0;
            seg_en_q  <= '0;
            seg_dp_q  <= '0;
            irqen_q   <= '0;
            evt_q     <= '0;
            lvl_q     <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            for (int i = 0; i < NUM_BTN; i++) deb_cnt[i] <= '0;
            scan_cnt  <= '0;
            dig_idx   <= '0;
            seg       <= 8'hFF;
            an        <= '1;
            irq       <= 1'b0;
`ifdef BOARD_IO_RAW_SEG_EN
            raw_mode_q <= 1'b0;
            segraw_q   <= '0;
`endif
        end else begin
            if (wr) begin
                case (word)
                    3'd0: led_q     <= data_i[NUM_LED-1:0];
                    3'd1: segdata_q <= data_i[4*NUM_DIGITS-1:0];
                    3'd2: begin
                        seg_en_q <= data_i[NUM_DIGITS-1:0];
                        seg_dp_q <= data_i[8 +: NUM_DIGITS];
`ifdef BOARD_IO_RAW_SEG_EN
                        raw_mode_q <= data_i[16];
`endif
                    end
                    3'd6: irqen_q   <= data_i[NUM_BTN-1:0];
`ifdef BOARD_IO_RAW_SEG_EN
                    3'd7: segraw_q  <= data_i;
`endif
                    default: ;
                endcase
            end

            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;

            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_s2[i] == lvl_q[i] || deb_done[i]) deb_cnt[i] <= '0;
                else                                      deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
            lvl_q <= lvl_q ^ deb_done;
            // A new edge wins over a same-cycle clear so no press is lost.
            evt_q <= (evt_q & ~w1c) | rise;
            irq   <= |(evt_q & irqen_q);

            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            seg <= seg_nxt;
            an  <= cur_en ? ~(NUM_DIGITS'(1) << dig_idx) : '1;
        end
    end

    always_comb begin
        rd = '0;
        case (word)
            3'd0: rd[NUM_LED-1:0]      = led_q;
            3'd1: rd[4*NUM_DIGITS-1:0] = segdata_q;
            3'd2: begin
                rd[NUM_DIGITS-1:0]  = seg_en_q;
                rd[8 +: NUM_DIGITS] = seg_dp_q;
`ifdef BOARD_IO_RAW_SEG_EN
                rd[16] = raw_mode_q;
`endif
            end
            3'd3: rd[NUM_SW-1:0]  = sw_s2;
            3'd4: rd[NUM_BTN-1:0] = lvl_q;
            3'd5: rd[NUM_BTN-1:0] = evt_q;
            3'd6: rd[NUM_BTN-1:0] = irqen_q;
`ifdef BOARD_IO_RAW_SEG_EN
            3'd7: rd = segraw_q;
`endif
            default: rd = '0;
        endcase
    end
    assign data_o = (ce && !we) ? rd : '0;

endmodule
